// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and FSM encodings for the MMIO UART.
package uart_pkg;

   localparam logic [3:0] ADDR_STATUS = 4'h0;
   localparam logic [3:0] ADDR_RXDATA = 4'h4;
   localparam logic [3:0] ADDR_TXDATA = 4'h8;
   localparam logic [3:0] ADDR_DIV    = 4'hC;

   localparam int ST_TX_READY  = 0;
   localparam int ST_RX_VALID  = 1;
   localparam int ST_OVERRUN   = 2;
   localparam int ST_FRAME_ERR = 3;
   localparam int ST_TX_BUSY   = 4;

   localparam logic [15:0] DIV_MIN = 16'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_e;

   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < DIV_MIN) ? DIV_MIN : v;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with show-ahead read data; push and pop may coincide at any occupancy.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // a full FIFO still accepts a push when an entry leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped UART: register file, TX/RX FIFOs, TX and RX framing FSMs.
// state   | meaning
// S_IDLE  | line idle, waiting for TX data / RX falling edge
// S_START | start bit (TX driving 0, RX waiting for mid-bit re-sample)
// S_DATA  | data bits, LSB first
// S_STOP  | stop bit (TX driving 1, RX checking for 1)
module mmio_uart
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_RESET  = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  addr,
   input  logic [3:0]  we,
   input  logic        re,
   input  logic [31:0] din,
   output logic [31:0] dout,
   input  logic        FPGA_SERIAL_RX,
   output logic        FPGA_SERIAL_TX,
   output logic        irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [15:0]          div_q, div_next;
   logic                 overrun_q, frame_err_q;
   logic [31:0]          status;
   logic                 unused_bits;

   logic                 tx_push, tx_pop, tx_full, tx_empty;
   logic [DATA_BITS-1:0] tx_rdata;
   logic [CW-1:0]        tx_count;
   logic                 rx_pop, rx_full, rx_empty;
   logic [DATA_BITS-1:0] rx_rdata;
   logic [CW-1:0]        rx_count;

   uart_state_e          tx_state;
   logic [15:0]          tx_cnt, tx_div;
   logic [3:0]           tx_idx;
   logic [DATA_BITS-1:0] tx_shift;

   uart_state_e          rx_state;
   logic                 rx_s1, rx_s2, rx_prev;
   logic [15:0]          rx_cnt, rx_div;
   logic [3:0]           rx_idx;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_push, rx_ferr;

   assign unused_bits = ^{din[31:16], we[3:2]};

   assign tx_push = (addr == ADDR_TXDATA) && we[0];
   assign rx_pop  = re && (addr == ADDR_RXDATA);
   assign irq     = (rx_count != '0);

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(din[DATA_BITS-1:0]),
      .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_shift),
      .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   always_comb begin
      status = '0;
      status[ST_TX_READY]  = !tx_full;
      status[ST_RX_VALID]  = (rx_count != '0);
      status[ST_OVERRUN]   = overrun_q;
      status[ST_FRAME_ERR] = frame_err_q;
      status[ST_TX_BUSY]   = (tx_count != '0) || (tx_state != S_IDLE);
   end

   always_comb begin
      div_next = div_q;
      if (we[0]) div_next[7:0]  = din[7:0];
      if (we[1]) div_next[15:8] = din[15:8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q       <= 16'(DIV_RESET);
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         dout        <= '0;
      end else begin
         if ((addr == ADDR_DIV) && (we[1:0] != 2'b00)) div_q <= clamp_div(div_next);
         if (rx_push && rx_full && !rx_pop)
            overrun_q <= 1'b1;
         else if ((addr == ADDR_STATUS) && we[0] && din[ST_OVERRUN])
            overrun_q <= 1'b0;
         if (rx_ferr)
            frame_err_q <= 1'b1;
         else if ((addr == ADDR_STATUS) && we[0] && din[ST_FRAME_ERR])
            frame_err_q <= 1'b0;
         if (re) begin
            case (addr)
               ADDR_STATUS: dout <= status;
               ADDR_RXDATA: dout <= rx_empty ? '0 : 32'(rx_rdata);
               ADDR_DIV:    dout <= {16'h0, div_q};
               default:     dout <= '0;
            endcase
         end
      end
   end

   // STOP hands straight over to START when more data is queued
   assign tx_pop = !tx_empty &&
                   ((tx_state == S_IDLE) || ((tx_state == S_STOP) && (tx_cnt == '0)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state       <= S_IDLE;
         tx_cnt         <= '0;
         tx_div         <= '0;
         tx_idx         <= '0;
         tx_shift       <= '0;
         FPGA_SERIAL_TX <= 1'b1;
      end else if (tx_pop) begin
         tx_state       <= S_START;
         tx_div         <= div_q;
         tx_cnt         <= div_q - 16'd1;
         tx_shift       <= tx_rdata;
         FPGA_SERIAL_TX <= 1'b0;
      end else begin
         case (tx_state)
            S_IDLE: FPGA_SERIAL_TX <= 1'b1;
            S_START, S_DATA: begin
               if (tx_cnt == '0) begin
                  tx_cnt <= tx_div - 16'd1;
                  if ((tx_state == S_DATA) && (tx_idx == 4'(DATA_BITS - 1))) begin
                     tx_state       <= S_STOP;
                     FPGA_SERIAL_TX <= 1'b1;
                  end else begin
                     tx_idx         <= (tx_state == S_START) ? 4'd0 : tx_idx + 4'd1;
                     tx_state       <= S_DATA;
                     FPGA_SERIAL_TX <= tx_shift[0];
                     tx_shift       <= tx_shift >> 1;
                  end
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            S_STOP: begin
               if (tx_cnt == '0) tx_state <= S_IDLE;
               else              tx_cnt   <= tx_cnt - 16'd1;
            end
            default: tx_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_div   <= '0;
         rx_idx   <= '0;
         rx_shift <= '0;
         rx_push  <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_s1   <= FPGA_SERIAL_RX;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         rx_push <= 1'b0;
         rx_ferr <= 1'b0;
         case (rx_state)
            S_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_state <= S_START;
                  rx_div   <= div_q;
                  rx_cnt   <= (div_q >> 1) - 16'd1;
               end
            end
            S_START: begin
               if (rx_cnt == '0) begin
                  rx_state <= rx_s2 ? S_IDLE : S_DATA;
                  rx_cnt   <= rx_div - 16'd1;
                  rx_idx   <= '0;
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (rx_cnt == '0) begin
                  rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                  rx_cnt   <= rx_div - 16'd1;
                  if (rx_idx == 4'(DATA_BITS - 1)) rx_state <= S_STOP;
                  else                             rx_idx   <= rx_idx + 4'd1;
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            S_STOP: begin
               if (rx_cnt == '0) begin
                  rx_state <= S_IDLE;
                  rx_push  <= rx_s2;
                  rx_ferr  <= !rx_s2;
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart: register access, TX framing, loopback RX, errors, reset.
module tb_mmio_uart;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  addr = '0;
   logic [3:0]  we = '0;
   logic        re = 1'b0;
   logic [31:0] din = '0;
   logic [31:0] dout;
   logic        rx_drv = 1'b1;
   logic        loop = 1'b0;
   logic        rx_line, tx_line, irq;

   int checks = 0;
   int errors = 0;

   assign rx_line = loop ? tx_line : rx_drv;

   mmio_uart #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_RESET(868)) dut (
      .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .din(din), .dout(dout),
      .FPGA_SERIAL_RX(rx_line), .FPGA_SERIAL_TX(tx_line), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] w);
      addr = a; din = d; we = w;
      @(posedge clk);
      #1;
      we = '0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      addr = a; re = 1'b1;
      @(posedge clk);
      #1;
      re = 1'b0;
      d = dout;
   endtask

   task automatic wait_start(output int ok);
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (tx_line === 1'b0) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
      rx_drv = 1'b0;
      idle(div);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         idle(div);
      end
      rx_drv = stop;
      idle(div);
      rx_drv = 1'b1;
      idle(div);
   endtask

   initial begin
      logic [31:0] d;
      logic [39:0] trace;
      logic [9:0]  frame;
      logic [7:0]  ovr_bytes [5];
      int          ok;

      ovr_bytes[0] = 8'h11; ovr_bytes[1] = 8'h22; ovr_bytes[2] = 8'h33;
      ovr_bytes[3] = 8'h44; ovr_bytes[4] = 8'h55;

      idle(3);
      check("rst_dout", dout, 32'h0);
      check("rst_tx", 32'(tx_line), 32'h1);
      check("rst_irq", 32'(irq), 32'h0);
      rst = 1'b0;
      idle(2);
      rd(4'h0, d); check("rst_status", d, 32'h1);
      rd(4'hC, d); check("rst_div", d, 32'd868);

      wr(4'hC, 32'h2, 4'b0011);      rd(4'hC, d); check("div_clamp", d, 32'h4);
      wr(4'hC, 32'h1234, 4'b0001);   rd(4'hC, d); check("div_byte0", d, 32'h0034);
      wr(4'hC, 32'h0500, 4'b0010);   rd(4'hC, d); check("div_byte1", d, 32'h0534);

      // 0x55 at DIV=4: 10 bits of 4 cycles each
      wr(4'hC, 32'h4, 4'b0011);
      wr(4'h8, 32'h55, 4'b0001);
      wait_start(ok);
      check("tx55_start", 32'(ok), 32'h1);
      trace = '0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) idle(1);
         trace[i] = tx_line;
      end
      frame = {1'b1, 8'h55, 1'b0};
      for (int b = 0; b < 10; b++)
         check($sformatf("tx55_bit%0d", b), 32'(trace[4*b +: 4]), 32'({4{frame[b]}}));
      idle(1);
      check("tx55_idle", 32'(tx_line), 32'h1);
      rd(4'h0, d); check("tx55_status", d, 32'h1);

      // loopback at DIV=8
      wr(4'hC, 32'h8, 4'b0011);
      loop = 1'b1;
      wr(4'h8, 32'hA3, 4'b0001);
      wr(4'h8, 32'h00, 4'b0001);
      idle(300);
      rd(4'h4, d); check("loop_byte0", d, 32'hA3);
      rd(4'h4, d); check("loop_byte1", d, 32'h00);
      rd(4'h0, d); check("loop_status", d, 32'h1);
      check("loop_irq", 32'(irq), 32'h0);

      // overrun: five frames into a four-deep RX FIFO
      for (int i = 0; i < 5; i++) wr(4'h8, 32'(ovr_bytes[i]), 4'b0001);
      idle(520);
      rd(4'h0, d); check("ovr_status", d, 32'h7);
      check("ovr_irq", 32'(irq), 32'h1);
      for (int i = 0; i < 4; i++) begin
         rd(4'h4, d);
         check($sformatf("ovr_byte%0d", i), d, 32'(ovr_bytes[i]));
      end
      rd(4'h4, d); check("rx_empty_read", d, 32'h0);
      rd(4'h0, d); check("ovr_sticky", d, 32'h5);
      wr(4'h0, 32'h4, 4'b0001);
      rd(4'h0, d); check("ovr_clear", d, 32'h1);

      // externally driven frames
      loop = 1'b0;
      send_frame(8'h3C, 1'b1, 8);
      idle(10);
      rd(4'h0, d); check("ext_status", d, 32'h3);
      rd(4'h4, d); check("ext_byte", d, 32'h3C);
      send_frame(8'h5A, 1'b0, 8);
      idle(10);
      rd(4'h0, d); check("ferr_status", d, 32'h9);
      check("ferr_irq", 32'(irq), 32'h0);
      wr(4'h0, 32'h8, 4'b0001);
      rd(4'h0, d); check("ferr_clear", d, 32'h1);

      rx_drv = 1'b0;
      idle(1);
      rx_drv = 1'b1;
      idle(20);
      rd(4'h0, d); check("glitch_status", d, 32'h1);

      // reset during the third data bit of 0xF0 (bit value 0)
      wr(4'h8, 32'hF0, 4'b0001);
      wr(4'h8, 32'h33, 4'b0001);
      wait_start(ok);
      check("rstmid_start", 32'(ok), 32'h1);
      idle(26);
      check("rstmid_tx_low", 32'(tx_line), 32'h0);
      rst = 1'b1;
      #1;
      check("rstmid_tx_high", 32'(tx_line), 32'h1);
      check("rstmid_dout", dout, 32'h0);
      idle(2);
      rst = 1'b0;
      rd(4'h0, d); check("rstmid_status", d, 32'h1);
      rd(4'hC, d); check("rstmid_div", d, 32'd868);
      idle(20);
      check("rstmid_tx_quiet", 32'(tx_line), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
